// File: rtl/ipml_reg_fifo_rr_arb_if.sv
// Handshake bundle for ipml_reg_fifo_rr_arb.
// master: drives the upstream beats and the downstream ready (the environment).
// slave:  the arbiter itself.
interface ipml_reg_fifo_rr_arb_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
);
  logic [N-1:0]   s_valid;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_last;
  logic [N-1:0]   s_ready;
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic           m_ready;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ipml_reg_fifo_rr_arb.sv
// Round-robin arbiter feeding one register-FIFO output channel from N requesters.
// Beats pass through a 2-entry register buffer so m_ready never reaches s_ready
// combinationally.
// Optional feature macro: IPML_ARB_PKT_LOCK_EN
//   defined   -> grant held for a whole packet (until the s_last beat is accepted)
//   undefined -> every accepted beat releases the grant
module ipml_reg_fifo_rr_arb #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ipml_reg_fifo_rr_arb_if.slave bus,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);
  localparam int unsigned GW = $clog2(N);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic [GW-1:0] grant_q;

  // Two-entry buffer: {last, data} per entry plus a valid bit each.
  logic [W-1:0] buf_data_q [2];
  logic [1:0]   buf_last_q;
  logic [1:0]   buf_vld_q;
  logic [1:0]   buf_vld_d;
  logic         wr_ptr_q;
  logic         rd_ptr_q;

  logic          buf_not_full;
  logic          pick_found;
  logic [GW-1:0] pick_id;
  logic          gnt_valid;
  logic          gnt_last;
  logic [W-1:0]  gnt_data;
  logic          accept;
  logic          rd_en;
  logic          grant_done;

  assign buf_not_full = ~&buf_vld_q;

  // Round-robin pick: first valid requester searching from grant_q+1 modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_q;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned   idx;
      logic [GW-1:0] cand;
      idx  = (32'(grant_q) + k) % N;
      cand = GW'(idx);
      if (!pick_found && bus.s_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Mux the current grantee's beat.
  always_comb begin
    int unsigned base;
    base      = 32'(grant_q) * W;
    gnt_valid = bus.s_valid[grant_q];
    gnt_last  = bus.s_last[grant_q];
    gnt_data  = bus.s_data[base +: W];
  end

  // Only the grantee sees ready, and only while the buffer has room.
  always_comb begin
    bus.s_ready = '0;
    if (state_q == StBusy && buf_not_full) begin
      bus.s_ready[grant_q] = 1'b1;
    end
  end

  assign accept = (state_q == StBusy) && buf_not_full && gnt_valid;
  assign rd_en  = bus.m_valid && bus.m_ready;

  // Decide when the current grant ends.
  always_comb begin
`ifdef IPML_ARB_PKT_LOCK_EN
    grant_done = accept && gnt_last;
`else
    grant_done = accept;
`endif
  end

  // Arbitration FSM; grant_id and busy come straight from its registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= GW'(N - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q <= pick_id;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (grant_done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == StBusy);

  // Entry valid bits: clear on read first, then set on write; the two never hit
  // the same entry because a write only targets an empty slot.
  always_comb begin
    buf_vld_d = buf_vld_q;
    if (rd_en) begin
      buf_vld_d[rd_ptr_q] = 1'b0;
    end
    if (accept) begin
      buf_vld_d[wr_ptr_q] = 1'b1;
    end
  end

  // Buffer storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
      end
      buf_last_q <= '0;
      buf_vld_q  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      buf_vld_q <= buf_vld_d;
      if (accept) begin
        buf_data_q[wr_ptr_q] <= gnt_data;
        buf_last_q[wr_ptr_q] <= gnt_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.m_valid = |buf_vld_q;
  assign bus.m_data  = buf_data_q[rd_ptr_q];
  assign bus.m_last  = buf_last_q[rd_ptr_q];

  // Sanity: ready is never offered to more than one requester.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.s_ready));

  // Sanity: the read pointer always addresses a valid entry when m_valid is up.
  a_rd_valid: assert property (@(posedge clk) disable iff (!rst_n)
    bus.m_valid |-> buf_vld_q[rd_ptr_q]);

endmodule

// File: tb/tb_ipml_reg_fifo_rr_arb.sv
// Self-checking bench for ipml_reg_fifo_rr_arb (W=8, N=4).
// A source engine plays per-requester beat queues with valid/ready; a monitor
// pops expected {last,data} from a scoreboard on every output handshake.
module tb_ipml_reg_fifo_rr_arb;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy;

  always #5 clk = ~clk;

  ipml_reg_fifo_rr_arb_if #(.W(W), .N(N)) bus ();

  ipml_reg_fifo_rr_arb #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0] exp_q [$];
  logic [8:0] src_q [N][$];
  int         stall_at [N];
  int         stall_len [N];
  int         stall_left [N];
  int         sent [N];
  int         acc_id [$];
  int         acc_cyc [$];
  bit         eng_en = 1'b0;
  int         cyc = 0;

  // Source engine + output monitor.
  initial begin
    logic [N-1:0] fire;
    logic [8:0]   e;
    forever begin
      @(negedge clk);
      fire = '0;
      if (eng_en) begin
        for (int i = 0; i < N; i++) begin
          if (bus.s_valid[i] && bus.s_ready[i]) begin
            fire[i] = 1'b1;
            acc_id.push_back(i);
            acc_cyc.push_back(cyc);
          end
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected got=%h expected=none", {bus.m_last, bus.m_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_last, bus.m_data} !== e) begin
            failures++;
            $display("FAIL out_beat got=%h expected=%h", {bus.m_last, bus.m_data}, e);
          end
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (eng_en) begin
        for (int i = 0; i < N; i++) begin
          if (fire[i]) begin
            if (src_q[i].size() > 0) void'(src_q[i].pop_front());
            sent[i]++;
            if (sent[i] == stall_at[i]) stall_left[i] = stall_len[i];
          end else if (stall_left[i] > 0) begin
            stall_left[i]--;
          end
          if (src_q[i].size() > 0 && stall_left[i] == 0) begin
            bus.s_valid[i] = 1'b1;
            bus.s_last[i] = src_q[i][0][8];
            bus.s_data[i*W +: W] = src_q[i][0][7:0];
          end else begin
            bus.s_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic flush_tb();
    exp_q.delete();
    acc_id.delete();
    acc_cyc.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      stall_at[i] = 0;
      stall_len[i] = 0;
      stall_left[i] = 0;
      sent[i] = 0;
    end
    bus.s_valid = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush_tb();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    bit pending = 1'b1;
    while (pending && n < budget) begin
      @(negedge clk);
      n++;
      pending = (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) pending = 1'b1;
    end
    repeat (2) @(negedge clk);
    ok = !pending;
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b expected=0", bus.m_valid); end
    if (bus.m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data got=%h expected=00", bus.m_data); end
    if (bus.m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b expected=0", bus.m_last); end
    if (bus.s_ready !== 4'b0000) begin failures++; $display("FAIL rst_s_ready got=%b expected=0000", bus.s_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b expected=0", busy); end
    if (grant_id !== 2'd3) begin failures++; $display("FAIL rst_grant_id got=%0d expected=3", grant_id); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_first_beat();
    bit ok;
    @(posedge clk);
    #2;
    bus.m_ready = 1'b1;
    bus.s_valid = 4'b0001;
    bus.s_last = 4'b0001;
    bus.s_data[7:0] = 8'h11;
    exp_q.push_back({1'b1, 8'h11});
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 4'b0000) begin failures++; $display("FAIL first_arb_lat got=%b expected=0000", bus.s_ready); end
    @(negedge clk);
    checks += 2;
    if (bus.s_ready !== 4'b0001) begin failures++; $display("FAIL first_ready got=%b expected=0001", bus.s_ready); end
    if (grant_id !== 2'd0) begin failures++; $display("FAIL first_grant got=%0d expected=0", grant_id); end
    @(posedge clk);
    #1;
    bus.s_valid = 4'b0000;
    @(negedge clk);
    checks += 4;
    if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL first_m_valid got=%b expected=1", bus.m_valid); end
    if (bus.m_data !== 8'h11) begin failures++; $display("FAIL first_m_data got=%h expected=11", bus.m_data); end
    if (bus.m_last !== 1'b1) begin failures++; $display("FAIL first_m_last got=%b expected=1", bus.m_last); end
    if (busy !== 1'b0) begin failures++; $display("FAIL first_idle got=%b expected=0", busy); end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL first_drain got=pending expected=empty"); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        src_q[i].push_back({1'b1, 8'(i * 16 + k)});
        exp_q.push_back({1'b1, 8'(i * 16 + k)});
      end
    end
    wait_drain(200, ok);
    checks++;
    if (!ok || acc_id.size() != 12) begin
      failures++;
      $display("FAIL rr_count got=%0d expected=12", acc_id.size());
    end else begin
      for (int j = 0; j < 12; j++) begin
        checks++;
        if (acc_id[j] != j % 4) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=%0d expected=%0d", j, acc_id[j], j % 4);
        end
        if (j > 0) begin
          checks++;
          if (acc_cyc[j] - acc_cyc[j-1] != 2) begin
            failures++;
            $display("FAIL rr_gap idx=%0d got=%0d expected=2", j, acc_cyc[j] - acc_cyc[j-1]);
          end
        end
      end
    end
  endtask

  task automatic test_lock();
    bit ok;
    int exp_id [4];
    int exp_gap [4];
    do_reset();
    bus.m_ready = 1'b1;
    src_q[1].push_back({1'b0, 8'hA1});
    src_q[1].push_back({1'b0, 8'hA2});
    src_q[1].push_back({1'b1, 8'hA3});
    src_q[2].push_back({1'b1, 8'hB1});
`ifdef IPML_ARB_PKT_LOCK_EN
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b0, 8'hA2});
    exp_q.push_back({1'b1, 8'hA3});
    exp_q.push_back({1'b1, 8'hB1});
    exp_id = '{1, 1, 1, 2};
    exp_gap = '{0, 1, 1, 2};
`else
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hA2});
    exp_q.push_back({1'b1, 8'hA3});
    exp_id = '{1, 2, 1, 1};
    exp_gap = '{0, 2, 2, 2};
`endif
    wait_drain(200, ok);
    checks++;
    if (!ok || acc_id.size() != 4) begin
      failures++;
      $display("FAIL lock_count got=%0d expected=4", acc_id.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (acc_id[j] != exp_id[j]) begin
          failures++;
          $display("FAIL lock_order idx=%0d got=%0d expected=%0d", j, acc_id[j], exp_id[j]);
        end
        if (j > 0) begin
          checks++;
          if (acc_cyc[j] - acc_cyc[j-1] != exp_gap[j]) begin
            failures++;
            $display("FAIL lock_gap idx=%0d got=%0d expected=%0d", j,
                     acc_cyc[j] - acc_cyc[j-1], exp_gap[j]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_q[0].push_back({k == 4, 8'(8'hC0 + k)});
      exp_q.push_back({k == 4, 8'(8'hC0 + k)});
    end
    repeat (10) @(negedge clk);
    checks += 3;
    if (acc_id.size() != 2) begin failures++; $display("FAIL bp_accepted got=%0d expected=2", acc_id.size()); end
    if (bus.s_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_low got=%b expected=0000", bus.s_ready); end
    if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_m_valid got=%b expected=1", bus.m_valid); end
    @(posedge clk);
    #2;
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_passthru got=%b expected=0000", bus.s_ready); end
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 4'b0001) begin failures++; $display("FAIL bp_ready_back got=%b expected=0001", bus.s_ready); end
    wait_drain(200, ok);
    checks++;
    if (!ok || acc_id.size() != 5) begin
      failures++;
      $display("FAIL bp_total got=%0d expected=5", acc_id.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n = 0;
    int exp_id [3];
    do_reset();
    bus.m_ready = 1'b1;
    stall_at[2] = 1;
    stall_len[2] = 10;
    src_q[2].push_back({1'b0, 8'hD0});
    src_q[2].push_back({1'b1, 8'hD1});
    src_q[3].push_back({1'b1, 8'hE0});
`ifdef IPML_ARB_PKT_LOCK_EN
    exp_q.push_back({1'b0, 8'hD0});
    exp_q.push_back({1'b1, 8'hD1});
    exp_q.push_back({1'b1, 8'hE0});
    exp_id = '{2, 2, 3};
    while (sent[2] == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks += 2;
      if (grant_id !== 2'd2) begin failures++; $display("FAIL stall_grant cyc=%0d got=%0d expected=2", c, grant_id); end
      if (bus.s_ready[3] !== 1'b0) begin failures++; $display("FAIL stall_ready3 cyc=%0d got=%b expected=0", c, bus.s_ready[3]); end
    end
`else
    exp_q.push_back({1'b0, 8'hD0});
    exp_q.push_back({1'b1, 8'hE0});
    exp_q.push_back({1'b1, 8'hD1});
    exp_id = '{2, 3, 2};
`endif
    wait_drain(200, ok);
    checks++;
    if (!ok || acc_id.size() != 3) begin
      failures++;
      $display("FAIL stall_count got=%0d expected=3", acc_id.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (acc_id[j] != exp_id[j]) begin
          failures++;
          $display("FAIL stall_order idx=%0d got=%0d expected=%0d", j, acc_id[j], exp_id[j]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    bus.m_ready = 1'b0;
    stall_at[0] = 1;
    stall_len[0] = 1000;
    src_q[0].push_back({1'b0, 8'hF0});
    src_q[0].push_back({1'b0, 8'hF1});
    src_q[0].push_back({1'b1, 8'hF2});
    while (sent[0] == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL mrst_buffered got=%b expected=1", bus.m_valid); end
`ifdef IPML_ARB_PKT_LOCK_EN
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mrst_busy got=%b expected=1", busy); end
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL mrst_m_valid got=%b expected=0", bus.m_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy_clr got=%b expected=0", busy); end
    if (grant_id !== 2'd3) begin failures++; $display("FAIL mrst_grant got=%0d expected=3", grant_id); end
    if (bus.s_ready !== 4'b0000) begin failures++; $display("FAIL mrst_s_ready got=%b expected=0000", bus.s_ready); end
    flush_tb();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL mrst_idle got=%b expected=0", busy); end
    if (grant_id !== 2'd3) begin failures++; $display("FAIL mrst_grant_post got=%0d expected=3", grant_id); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL mrst_m_valid_post got=%b expected=0", bus.m_valid); end
  endtask

  initial begin
    bus.s_valid = '0;
    bus.s_last = '0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      stall_at[i] = 0;
      stall_len[i] = 0;
      stall_left[i] = 0;
      sent[i] = 0;
    end
    test_reset();
    test_first_beat();
    eng_en = 1'b1;
    test_round_robin();
    test_lock();
    test_backpressure();
    test_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
